rob: RTL

- In-order reorder buffer, directly upstream of the writeback stage.
- Dispatch allocates one entry per cycle in program order and receives a tag.
- Execution units write results by tag, out of order.
- Exposes the oldest 4 entries as commit slots; the writeback stage retires a contiguous completed prefix of them each cycle.

---
 rtl/rob_pkg.sv | 18 +
 rtl/rob_if.sv | 50 +++++
 rtl/rob.sv | 122 ++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Reorder buffer shared types: entry payload, commit width, tag width.
// Imported by rob and by the writeback stage.
package rob_pkg;

  localparam int ROB_COMMIT_W = 4;

  typedef struct packed {
    logic [4:0]  dest_reg;
    logic        dest_reg_valid;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
  } rob_entry_t;

  function automatic int rob_tag_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/rob_if.sv
// Dispatch / execute / writeback bundle of the reorder buffer.
// master = pipeline side, slave = rob.
interface rob_if
  import rob_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int NUM_WR = 2
) ();

  localparam int TW = rob_tag_w(DEPTH);

  logic          alloc_valid;
  logic [4:0]    alloc_dest_reg;
  logic          alloc_dest_reg_valid;
  logic          alloc_ready;
  logic [TW-1:0] alloc_tag;

  logic          wr_valid     [NUM_WR];
  logic [TW-1:0] wr_tag       [NUM_WR];
  logic [31:0]   wr_result_lo [NUM_WR];
  logic [31:0]   wr_result_hi [NUM_WR];

  logic          consume;
  logic [1:0]    consume_count;

  rob_entry_t    slot_data [ROB_COMMIT_W];
  logic [ROB_COMMIT_W-1:0] slot_valid;
  logic          empty;

  modport slave (
    input  alloc_valid, alloc_dest_reg,
    input  alloc_dest_reg_valid,
    output alloc_ready, alloc_tag,
    input  wr_valid, wr_tag,
    input  wr_result_lo, wr_result_hi,
    input  consume, consume_count,
    output slot_data, slot_valid, empty
  );

  modport master (
    output alloc_valid, alloc_dest_reg,
    output alloc_dest_reg_valid,
    input  alloc_ready, alloc_tag,
    output wr_valid, wr_tag,
    output wr_result_lo, wr_result_hi,
    output consume, consume_count,
    input  slot_data, slot_valid, empty
  );

endinterface

// File: rtl/rob.sv
// In-order reorder buffer feeding writeback with 4 commit slots.
// Optional ROB_FLUSH_EN adds a flush input that empties the buffer.
module rob
  import rob_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int NUM_WR = 2
) (
  input  logic clock,
  input  logic reset,
`ifdef ROB_FLUSH_EN
  input  logic flush,
`endif
  rob_if.slave bus
);

  localparam int TW = rob_tag_w(DEPTH);
  localparam int CW = TW + 1;

  logic [TW-1:0]    head;
  logic [TW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] occ;
  logic [DEPTH-1:0] done;
  rob_entry_t       mem [DEPTH];

  logic                    flush_i;
  logic [TW-1:0]           sidx [ROB_COMMIT_W];
  logic [ROB_COMMIT_W-1:0] sv;
  logic [2:0]              nvalid;
  logic [2:0]              nreq;
  logic [2:0]              nret;
  logic                    alloc_ready;
  logic                    alloc_fire;

`ifdef ROB_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  // Valid prefix: a slot counts only if every older slot is valid.
  always_comb begin
    logic chain;
    chain  = 1'b1;
    sv     = '0;
    nvalid = '0;
    for (int i = 0; i < ROB_COMMIT_W; i++) begin
      sidx[i] = head + TW'(i);
      sv[i]   = chain & occ[sidx[i]] & done[sidx[i]];
      chain   = sv[i];
      nvalid  = nvalid + 3'(sv[i]);
    end
  end

  always_comb begin
    nreq = {1'b0, bus.consume_count} + 3'd1;
    nret = '0;
    if (bus.consume)
      nret = (nreq < nvalid) ? nreq : nvalid;
  end

  assign alloc_ready = (count != CW'(DEPTH)) && !flush_i;
  assign alloc_fire  = bus.alloc_valid && alloc_ready;

  assign bus.alloc_ready = alloc_ready;
  assign bus.alloc_tag   = tail;
  assign bus.empty       = (count == '0);
  assign bus.slot_valid  = flush_i ? '0 : sv;

  always_comb begin
    for (int i = 0; i < ROB_COMMIT_W; i++)
      bus.slot_data[i] = mem[sidx[i]];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      occ   <= '0;
      done  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      occ   <= '0;
      done  <= '0;
    end else begin
      // Later ports are applied last, so the higher index wins.
      for (int p = 0; p < NUM_WR; p++) begin
        if (bus.wr_valid[p] && occ[bus.wr_tag[p]]) begin
          done[bus.wr_tag[p]]           <= 1'b1;
          mem[bus.wr_tag[p]].result_lo <= bus.wr_result_lo[p];
          mem[bus.wr_tag[p]].result_hi <= bus.wr_result_hi[p];
        end
      end
      for (int i = 0; i < ROB_COMMIT_W; i++) begin
        if (3'(i) < nret) begin
          occ[sidx[i]]  <= 1'b0;
          done[sidx[i]] <= 1'b0;
        end
      end
      if (alloc_fire) begin
        occ[tail]  <= 1'b1;
        done[tail] <= 1'b0;
        mem[tail]  <= '{
          dest_reg:       bus.alloc_dest_reg,
          dest_reg_valid: bus.alloc_dest_reg_valid,
          result_lo:      32'd0,
          result_hi:      32'd0
        };
        tail <= tail + 1'b1;
      end
      head  <= head + TW'(nret);
      count <= count + CW'(alloc_fire) - CW'(nret);
    end
  end

endmodule
